// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences the PC, issues single-outstanding word fetches
// to instruction memory, and buffers returned words in order for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Gnt,
  input  logic        IMEM_RValid,
  input  logic [31:0] IMEM_RData,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic [31:0] Instr_PC4
);

  localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               req;
  logic               req_nxt;
  logic [31:0]        pc;
  logic [31:0]        req_pc_p0;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [31:0]        instr_mem [FIFO_DEPTH];
  logic [31:0]        pc_mem    [FIFO_DEPTH];
  logic               grant;
  logic               push;
  logic               pop;
  logic               head_vld;

  assign grant    = req && IMEM_Gnt;
  assign head_vld = (count != '0);
  // A redirect kills both the incoming word and the decode handshake in the same cycle.
  assign push     = (state == S_WAIT) && IMEM_RValid && !Redirect_En;
  assign pop      = head_vld && Instr_Ready && !Redirect_En;

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (grant) state_nxt = S_WAIT;
      S_WAIT:  if (IMEM_RValid) state_nxt = S_REQ;
      S_DROP:  if (IMEM_RValid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
    // An outstanding request that is still unanswered after a redirect must be drained.
    if (Redirect_En) begin
      if (state == S_REQ) state_nxt = grant ? S_DROP : S_REQ;
      else                state_nxt = IMEM_RValid ? S_REQ : S_DROP;
    end
  end

  always_comb begin
    if (Redirect_En) count_nxt = '0;
    else             count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Issuing only with a free slot reserves room for the returning word.
  assign req_nxt = (state_nxt == S_REQ) && (count_nxt < CNT_W'(FIFO_DEPTH));

  // Control state: FSM, request flag, PC and buffer pointers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_REQ;
      req   <= 1'b0;
      pc    <= RESET_PC & WORD_MASK;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      count <= count_nxt;
      if (Redirect_En) begin
        pc   <= Redirect_PC & WORD_MASK;
        head <= '0;
        tail <= '0;
      end else begin
        if (grant) pc   <= pc + 32'd4;
        if (push)  tail <= tail + PTR_W'(1);
        if (pop)   head <= head + PTR_W'(1);
      end
    end
  end

  // Data path: address of the request in flight and the buffer storage.
  always_ff @(posedge CLK) begin
    if (grant) req_pc_p0 <= pc;
    if (push) begin
      instr_mem[tail] <= IMEM_RData;
      pc_mem[tail]    <= req_pc_p0;
    end
  end

  assign IMEM_Req    = req;
  assign IMEM_Addr   = pc;
  assign Instr_Valid = head_vld;
  assign Instr       = head_vld ? instr_mem[head]       : NOP;
  assign Instr_PC    = head_vld ? pc_mem[head]          : 32'd0;
  assign Instr_PC4   = head_vld ? pc_mem[head] + 32'd4  : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-then-random bench for fetch_unit: a bus-level memory responder plus a
// program-order model of which PCs must be fetched and delivered to decode.
module tb_fetch_unit;

  localparam logic [31:0] PC_A = 32'h0000_0000;
  localparam logic [31:0] PC_B = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Redirect_En = 1'b0;
  logic [31:0] Redirect_PC = 32'd0;
  logic        IMEM_Gnt = 1'b0;
  logic        IMEM_RValid = 1'b0;
  logic [31:0] IMEM_RData = 32'd0;
  logic        Instr_Ready = 1'b0;

  logic        IMEM_Req, Instr_Valid;
  logic [31:0] IMEM_Addr, Instr, Instr_PC, Instr_PC4;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;

  fetch_unit #(.RESET_PC(PC_A), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .Redirect_En(Redirect_En), .Redirect_PC(Redirect_PC),
    .IMEM_Req(IMEM_Req), .IMEM_Addr(IMEM_Addr), .IMEM_Gnt(IMEM_Gnt),
    .IMEM_RValid(IMEM_RValid), .IMEM_RData(IMEM_RData),
    .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready), .Instr(Instr),
    .Instr_PC(Instr_PC), .Instr_PC4(Instr_PC4)
  );

  fetch_unit #(.RESET_PC(PC_B), .FIFO_DEPTH(2)) dut_w (
    .CLK(CLK), .RST(RST), .Redirect_En(Redirect_En), .Redirect_PC(Redirect_PC),
    .IMEM_Req(w_req), .IMEM_Addr(w_addr), .IMEM_Gnt(IMEM_Gnt),
    .IMEM_RValid(IMEM_RValid), .IMEM_RData(IMEM_RData),
    .Instr_Valid(w_valid), .Instr_Ready(Instr_Ready), .Instr(w_instr),
    .Instr_PC(w_pc), .Instr_PC4(w_pc4)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int fails   = 0;

  // stimulus knobs
  int gnt_pct = 100, ready_pct = 100, redir_pct = 0, rst_pct = 0;
  int lat_min = 1, lat_max = 1;
  bit hold_gnt = 0, rst_req = 0, redir_req = 0, rand_tgt = 0;
  bit redir_on_rv = 0, redir_on_gnt = 0, redir_on_wait = 0, rst_on_wait = 0;
  logic [31:0] fix_tgt = 32'd0;

  // reference model state
  logic [31:0] exp_pc = PC_A;
  logic [31:0] exp_fetch = PC_A;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  bit          rst_prev = 1, rst_prev2 = 1, flush_prev = 0, hold_prev = 0, req_due = 0;
  logic [31:0] prev_addr = 32'd0;
  int          delivered = 0;
  bit          chk_w = 1;
  int          w_grants = 0, w_deliv = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit rv, gnt, rdy, redir, rst, busy_before;
    logic [31:0] tgt, wexp;
    @(negedge CLK);
    busy_before = mem_busy;
    rv = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1;
        mem_busy = 1'b0;
      end
    end
    gnt = IMEM_Req && !hold_gnt && (int'($urandom_range(99)) < gnt_pct);
    rdy = int'($urandom_range(99)) < ready_pct;
    rst = rst_req || (rst_on_wait && mem_busy) || (int'($urandom_range(99)) < rst_pct);
    redir = redir_req || (redir_on_rv && rv) || (redir_on_gnt && gnt) ||
            (redir_on_wait && mem_busy) || (int'($urandom_range(99)) < redir_pct);
    if (redir) begin
      redir_req = 0; redir_on_rv = 0; redir_on_gnt = 0; redir_on_wait = 0;
    end
    if (rst) rst_on_wait = 0;
    tgt = rand_tgt ? $urandom : fix_tgt;

    RST         = rst;
    Redirect_En = redir;
    Redirect_PC = tgt;
    IMEM_Gnt    = gnt;
    IMEM_RValid = rv;
    IMEM_RData  = rv ? mem_word(mem_addr) : $urandom;
    Instr_Ready = rdy;

    chk("one_outstanding", {31'd0, IMEM_Req & busy_before}, 32'd0);
    if (rst_prev) begin
      chk("req_after_rst", {31'd0, IMEM_Req}, 32'd0);
      chk("valid_after_rst", {31'd0, Instr_Valid}, 32'd0);
    end else if (rst_prev2) begin
      chk("first_req_after_rst", {31'd0, IMEM_Req}, 32'd1);
    end
    if (flush_prev) chk("valid_after_redirect", {31'd0, Instr_Valid}, 32'd0);
    if (req_due)    chk("req_after_redirect", {31'd0, IMEM_Req}, 32'd1);
    if (hold_prev) begin
      chk("req_hold", {31'd0, IMEM_Req}, 32'd1);
      chk("addr_hold", IMEM_Addr, prev_addr);
    end
    if (!Instr_Valid) begin
      chk("idle_instr", Instr, NOP);
      chk("idle_pc", Instr_PC, 32'd0);
      chk("idle_pc4", Instr_PC4, 32'd0);
    end
    if (Instr_Valid && rdy && !redir && !rst) begin
      chk("deliver_pc", Instr_PC, exp_pc);
      chk("deliver_instr", Instr, mem_word(exp_pc));
      chk("deliver_pc4", Instr_PC4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (gnt && !rst) begin
      chk("fetch_addr", IMEM_Addr, exp_fetch);
      mem_busy  = 1'b1;
      mem_cnt   = int'($urandom_range(lat_max, lat_min));
      mem_addr  = IMEM_Addr;
      exp_fetch = exp_fetch + 32'd4;
    end
    if (chk_w) begin
      if (gnt) begin
        wexp = PC_B + 32'(w_grants * 4);
        chk("wrap_fetch_addr", w_addr, wexp);
        w_grants++;
      end
      if (w_valid && rdy && !redir && !rst) begin
        wexp = PC_B + 32'(w_deliv * 4);
        chk("wrap_pc", w_pc, wexp);
        chk("wrap_pc4", w_pc4, wexp + 32'd4);
        w_deliv++;
      end
    end

    req_due = redir && !rst && !gnt && !mem_busy;
    if (rst) begin
      exp_pc = PC_A; exp_fetch = PC_A; mem_busy = 1'b0;
    end else if (redir) begin
      exp_pc = tgt & 32'hFFFF_FFFC; exp_fetch = tgt & 32'hFFFF_FFFC;
    end
    rst_prev2  = rst_prev;
    rst_prev   = rst;
    flush_prev = redir && !rst;
    hold_prev  = IMEM_Req && !gnt && !redir && !rst;
    prev_addr  = IMEM_Addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int d0;

  initial begin
    // reset, then back-to-back 1-cycle memory with decode always ready
    rst_req = 1; cycle(); cycle(); rst_req = 0;
    run(6);
    d0 = delivered;
    run(20);
    chk("throughput_1_per_2", 32'(delivered - d0), 32'd10);
    chk("wrap_coverage", {31'd0, w_deliv >= 3}, 32'd1);
    chk_w = 0;

    // decode stall fills the buffer, then drains in order
    ready_pct = 0;
    run(10);
    chk("stall_req_low", {31'd0, IMEM_Req}, 32'd0);
    chk("stall_valid", {31'd0, Instr_Valid}, 32'd1);
    ready_pct = 100;
    d0 = delivered;
    run(12);
    chk("drain_count", 32'(delivered - d0), 32'd7);

    // redirect while waiting on a slow memory
    lat_min = 3; lat_max = 3; fix_tgt = 32'h0000_0103; redir_on_wait = 1;
    run(14);

    // redirect coinciding with RValid, then with Gnt
    lat_min = 1; lat_max = 1;
    fix_tgt = 32'h0000_2000; redir_on_rv = 1;  run(8);
    fix_tgt = 32'h0000_3000; redir_on_gnt = 1; run(8);

    // grant withheld, then reset in the middle of a wait
    hold_gnt = 1; run(5);
    chk("held_req", {31'd0, IMEM_Req}, 32'd1);
    chk("held_addr", IMEM_Addr, exp_fetch);
    hold_gnt = 0;
    lat_min = 4; lat_max = 4; rst_on_wait = 1;
    run(12);

    // randomized traffic
    lat_min = 1; lat_max = 4; gnt_pct = 60; ready_pct = 70;
    redir_pct = 4; rst_pct = 1; rand_tgt = 1;
    run(600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
